// File: rtl/mdu51_pkg.sv
// mdu51 shared constants: operand width, op codes,
// FSM state encoding and iteration count.
package mdu51_pkg;

  localparam int DATA_W   = 8;
  localparam int PROD_W   = 2 * DATA_W;
  localparam int ITER_CNT = 8;
  localparam int CNT_W    = $clog2(ITER_CNT);

  localparam logic MDU_MUL = 1'b0;
  localparam logic MDU_DIV = 1'b1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(ITER_CNT - 1);

  // Zero-extend an operand to accumulator width.
  function automatic logic [PROD_W-1:0] zext(
    input logic [DATA_W-1:0] v
  );
    return {{DATA_W{1'b0}}, v};
  endfunction

endpackage

// File: rtl/mdu51_step.sv
// mdu51_step: one combinational MUL shift-add or DIV
// restoring shift-subtract iteration, selected by op.
// Ports: op, cnt (iteration index), acc (product or
// {remainder, dividend/quotient}), opa (multiplicand),
// opb (multiplier or divisor) -> acc_nxt, opb_nxt.
module mdu51_step
  import mdu51_pkg::*;
(
  input  logic              op,
  input  logic [CNT_W-1:0]  cnt,
  input  logic [PROD_W-1:0] acc,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  output logic [PROD_W-1:0] acc_nxt,
  output logic [DATA_W-1:0] opb_nxt
);

  logic [PROD_W-1:0] addend;
  logic [DATA_W:0]   shifted;
  logic [DATA_W-1:0] diff;
  logic              fits;

  always_comb begin
    addend  = zext(opa) << cnt;
    // Partial remainder with the next dividend bit
    // appended; the extra top bit carries the sign
    // of the trial subtraction.
    shifted = {acc[PROD_W-1:DATA_W], acc[DATA_W-1]};
    fits    = shifted >= {1'b0, opb};
    // When fits, the difference is below the divisor
    // and so always fits in DATA_W bits.
    diff    = shifted[DATA_W-1:0] - opb;
    acc_nxt = acc;
    opb_nxt = opb;
    if (op == MDU_DIV) begin
      acc_nxt[PROD_W-1:DATA_W] =
        fits ? diff : shifted[DATA_W-1:0];
      acc_nxt[DATA_W-1:0] =
        {acc[DATA_W-2:0], fits};
    end else begin
      if (opb[0]) begin
        acc_nxt = acc + addend;
      end
      opb_nxt = opb >> 1;
    end
  end

endmodule

// File: rtl/mdu51_seq.sv
// mdu51_seq: sequential 8051 MUL AB / DIV AB unit, one
// bit per clock. Optional macro MDU51_EARLY_TERM_EN lets
// MUL finish once the remaining multiplier bits are 0.
// Ports: clk, rst_n (async, active low), Start, Op
// (0 MUL, 1 DIV), A, B in; Busy, Done, ResultA,
// ResultB, Carry, OVerflow out.
module mdu51_seq
  import mdu51_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Start,
  input  logic              Op,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] ResultA,
  output logic [DATA_W-1:0] ResultB,
  output logic              Carry,
  output logic              OVerflow
);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              op_q;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [PROD_W-1:0] acc;

  logic [PROD_W-1:0] acc_nxt;
  logic [DATA_W-1:0] opb_nxt;

  logic              done_q;
  logic [DATA_W-1:0] res_a;
  logic [DATA_W-1:0] res_b;
  logic              cy_q;
  logic              ov_q;

  logic              div_zero;
  logic              mul_skip;
  logic              mul_stop;
  logic              last;

  mdu51_step u_step (
    .op      (op_q),
    .cnt     (cnt),
    .acc     (acc),
    .opa     (opa),
    .opb     (opb),
    .acc_nxt (acc_nxt),
    .opb_nxt (opb_nxt)
  );

  assign div_zero = (Op == MDU_DIV) && (B == '0);

`ifdef MDU51_EARLY_TERM_EN
  assign mul_skip = (Op == MDU_MUL) && (B == '0);
  assign mul_stop = (op_q == MDU_MUL)
                 && (opb_nxt == '0);
`else
  assign mul_skip = 1'b0;
  assign mul_stop = 1'b0;
`endif

  assign last = (cnt == CNT_LAST) || mul_stop;

  // FSM, counter and working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_q  <= MDU_MUL;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (Start) begin
            op_q <= Op;
            opa  <= A;
            opb  <= B;
            cnt  <= '0;
            // DIV keeps the dividend in the low half;
            // MUL starts from a zero product.
            acc  <= (Op == MDU_DIV) ? zext(A) : '0;
            if (div_zero || mul_skip) begin
              state <= ST_DONE;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          acc <= acc_nxt;
          opb <= opb_nxt;
          if (last) begin
            state <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Results and flags change only when an operation
  // completes; the Done pulse follows the DONE state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      res_a  <= '0;
      res_b  <= '0;
      cy_q   <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      done_q <= (state == ST_DONE);
      if (state == ST_IDLE && Start) begin
        if (div_zero) begin
          res_a <= A;
          res_b <= B;
          cy_q  <= 1'b0;
          ov_q  <= 1'b1;
        end else if (mul_skip) begin
          res_a <= '0;
          res_b <= '0;
          cy_q  <= 1'b0;
          ov_q  <= 1'b0;
        end
      end else if (state == ST_RUN && last) begin
        res_a <= acc_nxt[DATA_W-1:0];
        res_b <= acc_nxt[PROD_W-1:DATA_W];
        cy_q  <= 1'b0;
        ov_q  <= (op_q == MDU_MUL)
              && (|acc_nxt[PROD_W-1:DATA_W]);
      end
    end
  end

  assign Busy     = (state != ST_IDLE);
  assign Done     = done_q;
  assign ResultA  = res_a;
  assign ResultB  = res_b;
  assign Carry    = cy_q;
  assign OVerflow = ov_q;

endmodule

// File: tb/tb_mdu51_seq.sv
// Self-checking bench for mdu51_seq: arithmetic model
// compared every cycle plus directed literal checks.
module tb_mdu51_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       Start = 1'b0;
  logic       Op = 1'b0;
  logic [7:0] A = 8'h00;
  logic [7:0] B = 8'h00;
  logic       Busy;
  logic       Done;
  logic [7:0] ResultA;
  logic [7:0] ResultB;
  logic       Carry;
  logic       OVerflow;

  int checks = 0;
  int errors = 0;

`ifdef MDU51_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam int LAT_0F = EARLY ? 5 : 9;
  localparam int LAT_23 = EARLY ? 2 : 9;
  localparam int LAT_B0 = EARLY ? 1 : 9;

  always #5 clk = ~clk;

  mdu51_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Start    (Start),
    .Op       (Op),
    .A        (A),
    .B        (B),
    .Busy     (Busy),
    .Done     (Done),
    .ResultA  (ResultA),
    .ResultB  (ResultB),
    .Carry    (Carry),
    .OVerflow (OVerflow)
  );

  // Edges from the start edge until Done is visible.
  function automatic int exp_lat(
    input logic op, input logic [7:0] b
  );
    int n;
    if (op) return (b == 8'h00) ? 1 : 9;
    if (!EARLY) return 9;
    if (b == 8'h00) return 1;
    n = 0;
    for (int i = 0; i < 8; i++) if (b[i]) n = i + 1;
    return n + 1;
  endfunction

  // Behavioural model state.
  int         m_rem = 0;
  int         m_prev;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic [7:0] m_ra = 8'h00;
  logic [7:0] m_rb = 8'h00;
  logic       m_ov = 1'b0;
  logic [7:0] p_ra;
  logic [7:0] p_rb;
  logic       p_ov;
  int         prod;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_rem  = 0;
      m_done = 1'b0;
      m_ra   = 8'h00;
      m_rb   = 8'h00;
      m_ov   = 1'b0;
    end else begin
      m_prev = m_rem;
      m_done = (m_prev == 1);
      if (m_prev > 0) begin
        m_rem = m_prev - 1;
      end else if (Start) begin
        m_rem = exp_lat(Op, B);
        if (Op && B == 8'h00) begin
          p_ra = A;
          p_rb = B;
          p_ov = 1'b1;
        end else if (Op) begin
          p_ra = A / B;
          p_rb = A % B;
          p_ov = 1'b0;
        end else begin
          prod = int'(A) * int'(B);
          p_ra = prod[7:0];
          p_rb = prod[15:8];
          p_ov = prod > 255;
        end
      end
      if (m_rem == 1) begin
        m_ra = p_ra;
        m_rb = p_rb;
        m_ov = p_ov;
      end
    end
    m_busy = (m_rem > 0);
    #1;
    checks++;
    if ({Busy, Done, Carry, OVerflow, ResultA, ResultB}
        !== {m_busy, m_done, 1'b0, m_ov, m_ra, m_rb})
    begin
      errors++;
      $display("FAIL cycle t=%0t got busy=%0b done=%0b cy=%0b ov=%0b ra=%h rb=%h exp busy=%0b done=%0b cy=0 ov=%0b ra=%h rb=%h",
        $time, Busy, Done, Carry, OVerflow, ResultA,
        ResultB, m_busy, m_done, m_ov, m_ra, m_rb);
    end
  end

  task automatic chk(
    input string name, input int act, input int exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h",
               name, act, exp);
    end
  endtask

  task automatic run_op(
    input string      name,
    input logic       op,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] ea,
    input logic [7:0] eb,
    input logic       eov,
    input int         elat
  );
    int  k;
    bit  seen;
    @(negedge clk);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
    A     = ~a;
    B     = 8'h5A;
    k     = 0;
    seen  = 1'b0;
    while (!seen && k < 20) begin
      @(posedge clk);
      k++;
      #1;
      if (Done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout no Done", name);
    end else begin
      chk({name, "_lat"}, k, elat);
      chk({name, "_ra"}, ResultA, ea);
      chk({name, "_rb"}, ResultB, eb);
      chk({name, "_ov"}, OVerflow, eov);
      chk({name, "_cy"}, Carry, 0);
    end
  endtask

  int ndone;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_res", {ResultA, ResultB}, 0);
    chk("rst_flags", {Carry, OVerflow}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op("mul50a0", 1'b0, 8'h50, 8'hA0,
           8'h00, 8'h32, 1'b1, 9);
    run_op("mul0f0f", 1'b0, 8'h0F, 8'h0F,
           8'hE1, 8'h00, 1'b0, LAT_0F);
    run_op("mulffff", 1'b0, 8'hFF, 8'hFF,
           8'h01, 8'hFE, 1'b1, 9);
    run_op("divfb12", 1'b1, 8'hFB, 8'h12,
           8'h0D, 8'h11, 1'b0, 9);
    run_op("div0507", 1'b1, 8'h05, 8'h07,
           8'h00, 8'h05, 1'b0, 9);
    run_op("div5500", 1'b1, 8'h55, 8'h00,
           8'h55, 8'h00, 1'b1, 1);
    run_op("mul2301", 1'b0, 8'h23, 8'h01,
           8'h23, 8'h00, 1'b0, LAT_23);
    run_op("mul7700", 1'b0, 8'h77, 8'h00,
           8'h00, 8'h00, 1'b0, LAT_B0);

    // Second Start during RUN must be ignored.
    @(negedge clk);
    Start = 1'b1; Op = 1'b0; A = 8'h12; B = 8'h34;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    Start = 1'b1; Op = 1'b1; A = 8'h99; B = 8'h03;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
    ndone = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (Done) ndone++;
    end
    chk("ign_ndone", ndone, 1);
    chk("ign_ra", ResultA, 8'hA8);
    chk("ign_rb", ResultB, 8'h03);
    chk("ign_ov", OVerflow, 1);

    // Reset during RUN aborts without Done.
    @(negedge clk);
    Start = 1'b1; Op = 1'b0; A = 8'hFF; B = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", Busy, 0);
    chk("abort_res", {ResultA, ResultB}, 0);
    chk("abort_flags", {Done, Carry, OVerflow}, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (Done) ndone++;
    end
    chk("abort_ndone", ndone, 0);
    run_op("post_rst", 1'b0, 8'h0F, 8'h0F,
           8'hE1, 8'h00, 1'b0, LAT_0F);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
